multi_code_lock_ctrl: RTL and testbench

MULTI_CODE_LOCK_CTRL -- requirements
Module: multi_code_lock_ctrl

---
 rtl/lock_pkg.sv | 36 +++
 rtl/code_entry_buf.sv | 42 ++++
 rtl/multi_code_lock_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_multi_code_lock_ctrl.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared key codes, FSM state encoding and the packed code word for the code lock.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lock_pkg;

  localparam int CODE_DIGIT_W = 4;
  localparam int CODE_MAX_LEN = 8;
  localparam int CODE_LEN_W   = $clog2(CODE_MAX_LEN + 1);

  localparam logic [CODE_DIGIT_W-1:0] KEY_LOCK   = 4'd9;
  localparam logic [CODE_DIGIT_W-1:0] KEY_PROG   = 4'd8;
  localparam logic [CODE_DIGIT_W-1:0] KEY_CANCEL = 4'd7;

  typedef enum logic [3:0] {
    S_IDLE          = 4'd0,
    S_ENTER_UC      = 4'd1,
    S_CHECK_UC      = 4'd2,
    S_TOGGLE        = 4'd3,
    S_ENTER_PC      = 4'd4,
    S_CHECK_PC      = 4'd5,
    S_ENTER_NEW     = 4'd6,
    S_ENTER_CONFIRM = 4'd7,
    S_COMMIT        = 4'd8,
    S_OK_BLINK      = 4'd9,
    S_FAIL_BLINK    = 4'd10,
    S_LOCKOUT       = 4'd11
  } state_t;

  // Digit i sits at digits[i*CODE_DIGIT_W +: CODE_DIGIT_W]; unused positions are zero,
  // so two words are equal exactly when length and entered digits are equal.
  typedef struct packed {
    logic [CODE_MAX_LEN*CODE_DIGIT_W-1:0] digits;
    logic [CODE_LEN_W-1:0]                len;
  } code_t;

endpackage

// File: rtl/code_entry_buf.sv
// Keypad entry buffer: collects digits into a packed code word, flags overflow.
// Latency: append/clear visible one cycle after the strobe.
// Backpressure: none; digits past MAX_LEN are dropped and set the overflow flag.
module code_entry_buf
  import lock_pkg::*;
#(
  parameter int DIGIT_W = CODE_DIGIT_W,
  parameter int MAX_LEN = CODE_MAX_LEN
) (
  input  logic                  hwclk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  app,
  input  logic [DIGIT_W-1:0]    digit,
  output logic [CODE_LEN_W-1:0] len,
  output logic                  ovf,
  output code_t                 word
);

  logic [CODE_MAX_LEN*CODE_DIGIT_W-1:0] digits;
  logic [CODE_LEN_W-1:0]                cnt;

  // Clear wins over append; a full buffer keeps its contents and only records the overflow.
  always_ff @(posedge hwclk) begin
    if (rst || clr) begin
      digits <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (app) begin
      if (cnt == CODE_LEN_W'(MAX_LEN)) begin
        ovf <= 1'b1;
      end else begin
        digits[32'(cnt)*DIGIT_W +: DIGIT_W] <= digit;
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign len  = cnt;
  assign word = '{digits: digits, len: cnt};

endmodule

// File: rtl/multi_code_lock_ctrl.sv
// Keypad code lock with several user slots, programmer-code reprogramming and failure lockout.
// Latency: a check resolves 1-2 cycles after the terminating key; blink/lockout phases are timed.
// Backpressure: none; keys arriving in non-entry states are simply ignored.
module multi_code_lock_ctrl
  import lock_pkg::*;
#(
  parameter int    DIGIT_W     = CODE_DIGIT_W,
  parameter int    MAX_LEN     = CODE_MAX_LEN,
  parameter int    MIN_LEN     = 4,
  parameter int    NUM_SLOTS   = 4,
  parameter int    MAX_FAILS   = 3,
  parameter int    LOCKOUT_CYC = 1000,
  parameter int    BLINK_CYC   = 100,
  parameter code_t PC_INIT     = '{digits: '0, len: CODE_LEN_W'(MIN_LEN)}
) (
  input  logic                           hwclk,
  input  logic                           rst,
  input  logic                           key_valid,
  input  logic [DIGIT_W-1:0]             key,
  input  logic [$clog2(NUM_SLOTS)-1:0]   slot_sel,
  output logic                           locked,
  output logic                           led_entry,
  output logic                           led_ok,
  output logic                           led_fail,
  output logic [3:0]                     state_o,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt_o
);

  localparam int SLOT_W  = $clog2(NUM_SLOTS);
  localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
  localparam int TMR_MAX = (LOCKOUT_CYC > BLINK_CYC) ? LOCKOUT_CYC : BLINK_CYC;
  // Bit 3 of the timer drives the 8-cycle blink, so keep at least four bits.
  localparam int TMR_W   = ($clog2(TMR_MAX + 1) < 4) ? 4 : $clog2(TMR_MAX + 1);

  state_t                state, state_n;
  logic [FAIL_W-1:0]     fail_cnt;
  logic [TMR_W-1:0]      timer;
  code_t                 slot_code [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  slot_vld;
  code_t                 pc_code, cand;
  logic [SLOT_W-1:0]     slot_tgt;

  logic                  k_lock, k_prog, k_cancel, k_digit, k_term;
  logic                  buf_clr, buf_app, buf_ovf, entry_bad, user_match, timed;
  logic                  do_toggle, do_commit, fail_inc, fail_clr, cand_ld, tgt_ld;
  logic                  blink_done, lock_done;
  logic [CODE_LEN_W-1:0] buf_len;
  code_t                 buf_word;

  assign k_lock    = key_valid && (key == KEY_LOCK);
  assign k_prog    = key_valid && (key == KEY_PROG);
  assign k_cancel  = key_valid && (key == KEY_CANCEL);
  assign k_digit   = key_valid && !k_lock && !k_prog && !k_cancel;
  // User entry terminates on LOCK; every programming entry terminates on PROG.
  assign k_term    = (state == S_ENTER_UC) ? k_lock : k_prog;
  assign entry_bad = (buf_len < CODE_LEN_W'(MIN_LEN)) || buf_ovf;

  assign timed      = (state == S_OK_BLINK) || (state == S_FAIL_BLINK) || (state == S_LOCKOUT);
  assign blink_done = (timer == TMR_W'(BLINK_CYC - 1));
  assign lock_done  = (timer == TMR_W'(LOCKOUT_CYC - 1));

  // Every ENTER_* state starts from an empty buffer, including ENTER_NEW -> ENTER_CONFIRM.
  assign buf_clr = (state_n != state) &&
                   (state_n inside {S_ENTER_UC, S_ENTER_PC, S_ENTER_NEW, S_ENTER_CONFIRM});

  code_entry_buf #(.DIGIT_W(DIGIT_W), .MAX_LEN(MAX_LEN)) u_buf (
    .hwclk (hwclk),
    .rst   (rst),
    .clr   (buf_clr),
    .app   (buf_app),
    .digit (key),
    .len   (buf_len),
    .ovf   (buf_ovf),
    .word  (buf_word)
  );

  // A user entry matches when any valid slot holds the same length and digits.
  always_comb begin
    user_match = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_vld[i] && (slot_code[i] == buf_word)) user_match = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge hwclk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state and control strobes; the key seen on a transition belongs to the old state.
  always_comb begin
    state_n   = state;
    buf_app   = 1'b0;
    do_toggle = 1'b0;
    do_commit = 1'b0;
    fail_inc  = 1'b0;
    fail_clr  = 1'b0;
    cand_ld   = 1'b0;
    tgt_ld    = 1'b0;
    case (state)
      S_IDLE: begin
        if (k_lock)      state_n = S_ENTER_UC;
        else if (k_prog) state_n = S_ENTER_PC;
      end
      S_ENTER_UC, S_ENTER_PC, S_ENTER_NEW, S_ENTER_CONFIRM: begin
        if (k_cancel) begin
          state_n = S_IDLE;
        end else if (k_digit) begin
          buf_app = 1'b1;
        end else if (k_term) begin
          if (entry_bad) begin
            state_n  = S_FAIL_BLINK;
            fail_inc = 1'b1;
          end else begin
            case (state)
              S_ENTER_UC:  state_n = S_CHECK_UC;
              S_ENTER_PC:  state_n = S_CHECK_PC;
              S_ENTER_NEW: begin
                cand_ld = 1'b1;
                state_n = S_ENTER_CONFIRM;
              end
              default: begin
                if (buf_word == cand) begin
                  state_n = S_COMMIT;
                end else begin
                  state_n  = S_FAIL_BLINK;
                  fail_inc = 1'b1;
                end
              end
            endcase
          end
        end
      end
      S_CHECK_UC: begin
        if (k_cancel) begin
          state_n = S_IDLE;
        end else if (user_match) begin
          state_n = S_TOGGLE;
        end else begin
          state_n  = S_FAIL_BLINK;
          fail_inc = 1'b1;
        end
      end
      S_CHECK_PC: begin
        if (k_cancel) begin
          state_n = S_IDLE;
        end else if (buf_word == pc_code) begin
          state_n = S_ENTER_NEW;
          tgt_ld  = 1'b1;
        end else begin
          state_n  = S_FAIL_BLINK;
          fail_inc = 1'b1;
        end
      end
      S_TOGGLE: begin
        do_toggle = 1'b1;
        fail_clr  = 1'b1;
        state_n   = S_OK_BLINK;
      end
      S_COMMIT: begin
        do_commit = 1'b1;
        fail_clr  = 1'b1;
        state_n   = S_OK_BLINK;
      end
      S_OK_BLINK: begin
        if (blink_done) state_n = S_IDLE;
      end
      S_FAIL_BLINK: begin
        if (blink_done) begin
          if (fail_cnt == FAIL_W'(MAX_FAILS)) state_n = S_LOCKOUT;
          else                                state_n = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (lock_done) begin
          fail_clr = 1'b1;
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Lock state, failure counter, phase timer and code storage.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      locked   <= 1'b1;
      fail_cnt <= '0;
      timer    <= '0;
      slot_vld <= NUM_SLOTS'(1);
      pc_code  <= PC_INIT;
      cand     <= '0;
      slot_tgt <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) slot_code[i] <= '0;
      slot_code[0] <= PC_INIT;
    end else begin
      if (do_toggle) locked <= ~locked;
      if (fail_clr)                                        fail_cnt <= '0;
      else if (fail_inc && fail_cnt != FAIL_W'(MAX_FAILS)) fail_cnt <= fail_cnt + 1'b1;
      // Timer restarts on every state change and only runs in the timed phases.
      if ((state_n != state) || !timed) timer <= '0;
      else                              timer <= timer + 1'b1;
      if (cand_ld) cand     <= buf_word;
      if (tgt_ld)  slot_tgt <= slot_sel;
      if (do_commit) begin
        slot_code[slot_tgt] <= cand;
        slot_vld[slot_tgt]  <= 1'b1;
      end
    end
  end

  assign state_o    = state;
  assign fail_cnt_o = fail_cnt;
  assign led_entry  = state inside {S_ENTER_UC, S_ENTER_PC, S_ENTER_NEW, S_ENTER_CONFIRM};
  assign led_ok     = (state == S_OK_BLINK) && !timer[3];
  assign led_fail   = ((state == S_FAIL_BLINK) && !timer[3]) || (state == S_LOCKOUT);

endmodule

// File: tb/tb_multi_code_lock_ctrl.sv
// Self-checking bench for multi_code_lock_ctrl: directed scenarios plus random operations
// checked against a code-list model of the lock (slots, lock state, failure count).
module tb_multi_code_lock_ctrl;
  import lock_pkg::*;

  localparam int NS       = 4;
  localparam int MAXF     = 3;
  localparam int LOCK_CYC = 1000;
  localparam int BLINK    = 100;

  logic       hwclk = 1'b0;
  logic       rst, key_valid;
  logic [3:0] key;
  logic [1:0] slot_sel;
  logic       locked, led_entry, led_ok, led_fail;
  logic [3:0] state_o;
  logic [1:0] fail_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: list of stored codes, the lock flag and the consecutive-failure count.
  bit     m_vld [NS];
  int     m_len [NS];
  longint m_val [NS];
  bit     m_locked;
  int     m_fails;
  int     q_a[$], q_b[$], q_c[$], q_t[$];

  always #5 hwclk = ~hwclk;

  multi_code_lock_ctrl dut (
    .hwclk      (hwclk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key        (key),
    .slot_sel   (slot_sel),
    .locked     (locked),
    .led_entry  (led_entry),
    .led_ok     (led_ok),
    .led_fail   (led_fail),
    .state_o    (state_o),
    .fail_cnt_o (fail_cnt_o)
  );

  function automatic longint pack_code(input int d[$]);
    longint v = 0;
    for (int i = 0; i < d.size() && i < 8; i++) v = v + (longint'(d[i]) << (4 * i));
    return v;
  endfunction

  function automatic bit entry_ok(input int d[$]);
    return (d.size() >= 4) && (d.size() <= 8);
  endfunction

  function automatic int rand_digit();
    int v;
    v = $urandom_range(0, 15);
    if (v >= 7 && v <= 9) v = v - 7;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_vld[i] = (i == 0);
      m_len[i] = (i == 0) ? 4 : 0;
      m_val[i] = 0;
    end
    m_locked = 1'b1;
    m_fails  = 0;
  endtask

  task automatic model_fail();
    if (m_fails < MAXF) m_fails++;
  endtask

  task automatic gen_rand(input int len);
    q_t.delete();
    repeat (len) q_t.push_back(rand_digit());
  endtask

  task automatic slot_to_q(input int s);
    q_t.delete();
    for (int j = 0; j < m_len[s]; j++) q_t.push_back(int'((m_val[s] >> (4 * j)) & 64'hF));
  endtask

  task automatic press(input int k);
    @(negedge hwclk);
    key_valid = 1'b1;
    key       = 4'(k);
    @(negedge hwclk);
    key_valid = 1'b0;
  endtask

  task automatic press_seq(input int d[$]);
    foreach (d[i]) press(d[i]);
  endtask

  // Follows a terminated entry through its blink (and lockout) phase back to IDLE.
  task automatic check_outcome(input bit exp_ok, input string tag);
    int         wait_c;
    int         cnt;
    logic [3:0] bs;
    wait_c = 0;
    bs = exp_ok ? 4'(S_OK_BLINK) : 4'(S_FAIL_BLINK);
    while (state_o != S_OK_BLINK && state_o != S_FAIL_BLINK && wait_c < 6) begin
      @(negedge hwclk);
      wait_c++;
    end
    n_checks++;
    if (state_o !== bs) begin
      n_errors++;
      $display("FAIL %s outcome: state_o=%0d expected=%0d", tag, state_o, bs);
      return;
    end
    n_checks++;
    if (locked !== m_locked) begin
      n_errors++;
      $display("FAIL %s locked: got=%0b expected=%0b", tag, locked, m_locked);
    end
    n_checks++;
    if (fail_cnt_o !== 2'(m_fails)) begin
      n_errors++;
      $display("FAIL %s fail_cnt: got=%0d expected=%0d", tag, fail_cnt_o, m_fails);
    end
    cnt = 0;
    while (state_o == bs && cnt < 4 * BLINK) begin
      n_checks++;
      if ((exp_ok ? led_ok : led_fail) !== 1'(((cnt / 8) % 2) == 0)) begin
        n_errors++;
        $display("FAIL %s blink led at cycle %0d: got=%0b", tag, cnt, exp_ok ? led_ok : led_fail);
      end
      cnt++;
      @(negedge hwclk);
    end
    n_checks++;
    if (cnt != BLINK) begin
      n_errors++;
      $display("FAIL %s blink length: got=%0d expected=%0d", tag, cnt, BLINK);
    end
    if (!exp_ok && m_fails == MAXF) begin
      n_checks++;
      if (state_o !== S_LOCKOUT) begin
        n_errors++;
        $display("FAIL %s lockout entry: state_o=%0d expected=%0d", tag, state_o, S_LOCKOUT);
        return;
      end
      cnt = 0;
      while (state_o == S_LOCKOUT && cnt < 3 * LOCK_CYC) begin
        n_checks++;
        if (led_fail !== 1'b1) begin
          n_errors++;
          $display("FAIL %s lockout led_fail at cycle %0d: got=%0b expected=1", tag, cnt, led_fail);
        end
        key_valid = (cnt == 10);
        key       = 4'd9;
        cnt++;
        @(negedge hwclk);
      end
      key_valid = 1'b0;
      n_checks++;
      if (cnt != LOCK_CYC) begin
        n_errors++;
        $display("FAIL %s lockout length: got=%0d expected=%0d", tag, cnt, LOCK_CYC);
      end
      m_fails = 0;
    end
    n_checks++;
    if (state_o !== S_IDLE) begin
      n_errors++;
      $display("FAIL %s return to idle: state_o=%0d expected=%0d", tag, state_o, S_IDLE);
    end
    n_checks++;
    if (locked !== m_locked || fail_cnt_o !== 2'(m_fails)) begin
      n_errors++;
      $display("FAIL %s final: locked=%0b/%0b fail_cnt=%0d/%0d", tag, locked, m_locked, fail_cnt_o, m_fails);
    end
  endtask

  // LOCK, digits in q_a, LOCK.
  task automatic do_unlock(input string tag);
    bit ok;
    ok = 1'b0;
    press(9);
    n_checks++;
    if (led_entry !== 1'b1) begin
      n_errors++;
      $display("FAIL %s led_entry: got=%0b expected=1", tag, led_entry);
    end
    press_seq(q_a);
    press(9);
    if (entry_ok(q_a))
      for (int i = 0; i < NS; i++)
        if (m_vld[i] && m_len[i] == q_a.size() && m_val[i] == pack_code(q_a)) ok = 1'b1;
    if (ok) begin
      m_locked = !m_locked;
      m_fails  = 0;
    end else begin
      model_fail();
    end
    check_outcome(ok, tag);
  endtask

  // PROG, q_a, PROG, q_b, PROG, q_c, PROG with the given target slot.
  task automatic do_program(input int slot, input string tag);
    slot_sel = 2'(slot);
    press(8);
    press_seq(q_a);
    press(8);
    if (!(q_a.size() == 4 && pack_code(q_a) == 0)) begin
      model_fail();
      check_outcome(1'b0, tag);
      return;
    end
    @(negedge hwclk);
    n_checks++;
    if (state_o !== S_ENTER_NEW) begin
      n_errors++;
      $display("FAIL %s enter_new: state_o=%0d expected=%0d", tag, state_o, S_ENTER_NEW);
    end
    slot_sel = 2'($urandom);
    press_seq(q_b);
    press(8);
    if (!entry_ok(q_b)) begin
      model_fail();
      check_outcome(1'b0, tag);
      return;
    end
    press_seq(q_c);
    press(8);
    if (!(entry_ok(q_c) && q_c.size() == q_b.size() && pack_code(q_c) == pack_code(q_b))) begin
      model_fail();
      check_outcome(1'b0, tag);
      return;
    end
    m_vld[slot] = 1'b1;
    m_len[slot] = q_b.size();
    m_val[slot] = pack_code(q_b);
    m_fails     = 0;
    check_outcome(1'b1, tag);
  endtask

  task automatic do_cancel(input string tag);
    press(9);
    press_seq(q_a);
    press(7);
    n_checks++;
    if (state_o !== S_IDLE) begin
      n_errors++;
      $display("FAIL %s cancel state: state_o=%0d expected=%0d", tag, state_o, S_IDLE);
    end
    n_checks++;
    if (fail_cnt_o !== 2'(m_fails) || locked !== m_locked) begin
      n_errors++;
      $display("FAIL %s cancel: fail_cnt=%0d/%0d locked=%0b/%0b", tag, fail_cnt_o, m_fails, locked, m_locked);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_valid = 1'b0;
    key = 4'd0;
    slot_sel = 2'd0;
    repeat (3) @(negedge hwclk);
    model_reset();
    n_checks++;
    if (state_o !== S_IDLE || locked !== 1'b1 || fail_cnt_o !== 2'd0) begin
      n_errors++;
      $display("FAIL reset state: state_o=%0d locked=%0b fail_cnt=%0d expected 0/1/0", state_o, locked, fail_cnt_o);
    end
    n_checks++;
    if ({led_entry, led_ok, led_fail} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset leds: got=%b expected=000", {led_entry, led_ok, led_fail});
    end
    rst = 1'b0;
  endtask

  task automatic test_unlock_default();
    q_a = '{0, 0, 0, 0};
    do_unlock("unlock_default");
  endtask

  task automatic test_program_slot();
    q_a = '{0, 0, 0, 0};
    q_b = '{1, 2, 3, 4, 5};
    q_c = '{1, 2, 3, 4, 5};
    do_program(2, "program_slot2");
    q_a = '{1, 2, 3, 4, 5};
    do_unlock("unlock_slot2");
  endtask

  task automatic test_lockout();
    q_a = '{1, 1, 1, 1};
    do_unlock("wrong_1");
    q_a = '{2, 2, 2, 2};
    do_unlock("wrong_2");
    q_a = '{3, 3, 3, 3};
    do_unlock("wrong_3");
  endtask

  task automatic test_overflow();
    q_a = '{1, 2, 3, 4, 5, 6, 1, 2, 3};
    do_unlock("overflow");
  endtask

  task automatic test_confirm_mismatch();
    q_a = '{0, 0, 0, 0};
    q_b = '{1, 2, 3, 4, 5};
    q_c = '{1, 2, 3, 4, 6};
    do_program(3, "confirm_mismatch_a");
    q_b = '{4, 5, 6, 1, 2};
    q_c = '{4, 5, 6, 1, 3};
    do_program(1, "confirm_mismatch_b");
    q_a = '{4, 5, 6, 1, 2};
    do_unlock("unlock_unwritten");
  endtask

  task automatic test_cancel();
    q_a = '{1, 2};
    do_cancel("cancel_uc");
  endtask

  task automatic test_reset_mid_confirm();
    slot_sel = 2'd1;
    press(8);
    press_seq('{0, 0, 0, 0});
    press(8);
    press_seq('{6, 5, 4, 3});
    press(8);
    press_seq('{6, 5, 4});
    @(negedge hwclk);
    rst = 1'b1;
    @(negedge hwclk);
    model_reset();
    n_checks++;
    if (state_o !== S_IDLE || locked !== 1'b1 || fail_cnt_o !== 2'd0 || led_entry !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_confirm: state_o=%0d locked=%0b fail_cnt=%0d led_entry=%0b", state_o, locked, fail_cnt_o, led_entry);
    end
    rst = 1'b0;
    q_a = '{6, 5, 4, 3};
    do_unlock("unlock_after_reset");
  endtask

  task automatic test_random();
    int op, s;
    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          s = $urandom_range(0, NS - 1);
          if ($urandom_range(0, 1) == 1 && m_vld[s]) slot_to_q(s);
          else gen_rand($urandom_range(3, 9));
          q_a = q_t;
          do_unlock("rand_unlock");
        end
        1: begin
          if ($urandom_range(0, 4) == 0) begin
            gen_rand($urandom_range(3, 5));
            q_a = q_t;
          end else begin
            q_a = '{0, 0, 0, 0};
          end
          gen_rand($urandom_range(3, 9));
          q_b = q_t;
          if ($urandom_range(0, 3) == 0) begin
            gen_rand(q_b.size());
            q_c = q_t;
          end else begin
            q_c = q_b;
          end
          do_program($urandom_range(0, NS - 1), "rand_program");
        end
        2: begin
          gen_rand($urandom_range(0, 9));
          q_a = q_t;
          do_cancel("rand_cancel");
        end
        default: begin
          press(rand_digit());
          press(7);
          n_checks++;
          if (state_o !== S_IDLE || led_entry !== 1'b0) begin
            n_errors++;
            $display("FAIL rand_idle_keys: state_o=%0d led_entry=%0b expected idle", state_o, led_entry);
          end
        end
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_unlock_default();
    test_program_slot();
    test_lockout();
    test_overflow();
    test_confirm_mismatch();
    test_cancel();
    test_reset_mid_confirm();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
